// File: rtl/bat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bat_pkg
//  Description : Shared constants for the program loader. Holds the state
//                encodings, the RAM direction codes on EXT_RAM_RW and the
//                default bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package bat_pkg;

    // Default bus widths of the CPU/RAM port
    localparam int unsigned C_ADDR_W = 16;
    localparam int unsigned C_DATA_W = 16;

    // EXT_RAM_RW encodings
    localparam logic RAM_WRITE = 1'b1;
    localparam logic RAM_READ  = 1'b0;

    // Loader state encodings
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SETTLE     = 3'd1;
    localparam logic [2:0] S_LOAD       = 3'd2;
    localparam logic [2:0] S_WR         = 3'd3;
    localparam logic [2:0] S_VERIFY_RD  = 3'd4;
    localparam logic [2:0] S_VERIFY_CAP = 3'd5;
    localparam logic [2:0] S_RELEASE    = 3'd6;

endpackage : bat_pkg
`default_nettype wire

// File: rtl/bat_bus_driver.sv
`default_nettype none
// ============================================================================
//  Module      : bat_bus_driver
//  Description : Tri-state driver for the shared RAM address and data pins.
//                Each bus floats unless its output enable is asserted.
//  Ports       : i_addr_oe / i_addr  - address enable and value
//                i_data_oe / i_data  - data enable and value
//                o_address           - RAM address pins (high-Z when idle)
//                io_data             - RAM data pins (high-Z when idle)
//  Revision    : 1.0 - initial release
// ============================================================================
module bat_bus_driver
    import bat_pkg::*;
#(
    parameter int unsigned ADDR_W = C_ADDR_W,
    parameter int unsigned DATA_W = C_DATA_W
) (
    input  logic              i_addr_oe,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_data_oe,
    input  logic [DATA_W-1:0] i_data,
    output wire  [ADDR_W-1:0] o_address,
    inout  wire  [DATA_W-1:0] io_data
);

    assign o_address = i_addr_oe ? i_addr : {ADDR_W{1'bz}};
    assign io_data   = i_data_oe ? i_data : {DATA_W{1'bz}};

endmodule : bat_bus_driver
`default_nettype wire

// File: rtl/bat_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : bat_program_loader
//  Description : Host-side master for the CPU halt / external-RAM port.
//                On a start request it halts the CPU, waits for the memory
//                controller to settle, writes a stream of program words into
//                RAM from a base address, then releases the bus and the halt.
//  Ports       : i_clk, i_rst          - clock, synchronous active-high reset
//                i_start               - begin a load (sampled only when idle)
//                i_base_addr           - first RAM address (captured on start)
//                i_word_count          - words to load (captured on start)
//                i_in_data/i_in_valid  - program word stream
//                o_in_ready            - word accepted this cycle when valid
//                o_halt                - CPU halt / RAM ownership
//                o_ext_ram_en/_rw      - RAM enable and direction (1 = write)
//                o_address, io_data    - tri-stated RAM address / data pins
//                o_busy, o_done        - load in progress / release pulse
//                o_verify_err          - sticky read-back checksum mismatch
//  Options     : LOADER_VERIFY_EN - when defined, the written span is read
//                back after the last write and its checksum compared with
//                the checksum of the words written.
//  Revision    : 1.0 - initial release
// ============================================================================
module bat_program_loader
    import bat_pkg::*;
#(
    parameter int unsigned ADDR_W        = C_ADDR_W,
    parameter int unsigned DATA_W        = C_DATA_W,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_word_count,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_halt,
    output logic              o_ext_ram_en,
    output logic              o_ext_ram_rw,
    output wire  [ADDR_W-1:0] o_address,
    inout  wire  [DATA_W-1:0] io_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_verify_err
);

    // Settle counter runs from SETTLE_CYCLES-1 down to 0, one SETTLE cycle per value
    localparam int unsigned       C_SET_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [C_SET_W-1:0] C_SETTLE_LAST = C_SET_W'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  C_ONE         = ADDR_W'(1);

    logic [2:0]         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_remain;
    logic [DATA_W-1:0]  r_hold;
    logic [C_SET_W-1:0] r_settle_cnt;

    logic w_wr;
    logic w_rd;

`ifdef LOADER_VERIFY_EN
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_count;
    logic [DATA_W-1:0] r_sum;
    logic [DATA_W-1:0] r_rsum;
    logic              r_verify_err;
    logic [DATA_W-1:0] w_rsum_next;

    assign w_rsum_next = r_rsum + io_data;
`endif

    // ------------------------------------------------------------------
    // Control FSM, address/count bookkeeping and checksums
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_remain     <= '0;
            r_hold       <= '0;
            r_settle_cnt <= '0;
`ifdef LOADER_VERIFY_EN
            r_base       <= '0;
            r_count      <= '0;
            r_sum        <= '0;
            r_rsum       <= '0;
            r_verify_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_addr       <= i_base_addr;
                        r_remain     <= i_word_count;
                        r_settle_cnt <= C_SETTLE_LAST;
                        r_state      <= S_SETTLE;
`ifdef LOADER_VERIFY_EN
                        r_base       <= i_base_addr;
                        r_count      <= i_word_count;
                        r_sum        <= '0;
                        r_verify_err <= 1'b0;
`endif
                    end
                end

                S_SETTLE: begin
                    if (r_settle_cnt != '0) begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end else if (r_remain == '0) begin
                        // Empty image: nothing to write, hand the CPU back
                        r_state <= S_RELEASE;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (i_in_valid) begin
                        r_hold  <= i_in_data;
                        r_state <= S_WR;
                    end
                end

                S_WR: begin
                    // RAM latches the word on this edge; address wraps naturally
                    r_addr   <= r_addr + C_ONE;
                    r_remain <= r_remain - C_ONE;
`ifdef LOADER_VERIFY_EN
                    r_sum    <= r_sum + r_hold;
`endif
                    if (r_remain == C_ONE) begin
`ifdef LOADER_VERIFY_EN
                        // Rewind to the base and walk the same span again
                        r_addr   <= r_base;
                        r_remain <= r_count;
                        r_rsum   <= '0;
                        r_state  <= S_VERIFY_RD;
`else
                        r_state  <= S_RELEASE;
`endif
                    end else begin
                        r_state <= S_LOAD;
                    end
                end

`ifdef LOADER_VERIFY_EN
                S_VERIFY_RD: begin
                    r_state <= S_VERIFY_CAP;
                end

                S_VERIFY_CAP: begin
                    r_rsum   <= w_rsum_next;
                    r_addr   <= r_addr + C_ONE;
                    r_remain <= r_remain - C_ONE;
                    if (r_remain == C_ONE) begin
                        if (w_rsum_next != r_sum) begin
                            r_verify_err <= 1'b1;
                        end
                        r_state <= S_RELEASE;
                    end else begin
                        r_state <= S_VERIFY_RD;
                    end
                end
`endif

                S_RELEASE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from the current state
    // ------------------------------------------------------------------
    assign w_wr = (r_state == S_WR);

`ifdef LOADER_VERIFY_EN
    // Enable held across both read-back cycles so the RAM keeps driving DATA
    // into the capture cycle
    assign w_rd         = (r_state == S_VERIFY_RD) || (r_state == S_VERIFY_CAP);
    assign o_verify_err = r_verify_err;
`else
    assign w_rd         = 1'b0;
    assign o_verify_err = 1'b0;
`endif

    assign o_busy       = (r_state != S_IDLE);
    assign o_halt       = (r_state != S_IDLE) && (r_state != S_RELEASE);
    assign o_done       = (r_state == S_RELEASE);
    assign o_in_ready   = (r_state == S_LOAD);
    assign o_ext_ram_en = w_wr || w_rd;
    assign o_ext_ram_rw = w_wr ? RAM_WRITE : RAM_READ;

    // Address only driven during an actual RAM access, data only while writing
    bat_bus_driver #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bus_driver (
        .i_addr_oe (o_ext_ram_en),
        .i_addr    (r_addr),
        .i_data_oe (w_wr),
        .i_data    (r_hold),
        .o_address (o_address),
        .io_data   (io_data)
    );

endmodule : bat_program_loader
`default_nettype wire

// File: tb/tb_bat_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bat_program_loader
//  Description : Self-checking bench for bat_program_loader with a simple RAM
//                model on the shared bus and a transaction-level reference
//                model of the load sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bat_program_loader;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst, start, valid;
    logic [15:0] base, count, din;
    logic        ready, halt, en, rw, busy, done, verr;
    wire  [15:0] address;
    wire  [15:0] dbus;

    int n_checks = 0;
    int n_errors = 0;

    // RAM model on the bus
    logic [15:0] mem [0:65535];
    logic        corrupt = 1'b0;
    logic [15:0] corrupt_addr = 16'h0;

    always #5 clk = ~clk;

    assign dbus = (en && !rw) ?
                  (mem[address] ^ ((corrupt && address == corrupt_addr) ? 16'h0100 : 16'h0000)) :
                  16'hzzzz;

    always @(posedge clk) begin
        if (en && rw) mem[address] <= dbus;
    end

    bat_program_loader #(
        .ADDR_W        (16),
        .DATA_W        (16),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_base_addr  (base),
        .i_word_count (count),
        .i_in_data    (din),
        .i_in_valid   (valid),
        .o_in_ready   (ready),
        .o_halt       (halt),
        .o_ext_ram_en (en),
        .o_ext_ram_rw (rw),
        .o_address    (address),
        .io_data      (dbus),
        .o_busy       (busy),
        .o_done       (done),
        .o_verify_err (verr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one load = settle period, then one write per word
    // accepted (write in the cycle after the handshake), optional read-back,
    // then a single release cycle.
    // ------------------------------------------------------------------
    bit          m_active = 0, m_release = 0, m_pending = 0, m_verifying = 0, m_err = 0;
    int          m_settle_left = 0, m_left = 0, m_count = 0, m_vidx = 0, m_writes = 0;
    logic [15:0] m_addr = 0, m_base = 0, m_data = 0;
    logic [15:0] exp_mem [0:65535];
    logic [15:0] touched[$];

    always @(negedge clk) begin
        check("halt",     32'(halt),  32'(m_active));
        check("busy",     32'(busy),  32'(m_active || m_release));
        check("done",     32'(done),  32'(m_release));
        check("in_ready", 32'(ready), 32'(m_active && m_settle_left == 0 && !m_pending &&
                                          !m_verifying && m_left != 0));
        check("ram_en",   32'(en),    32'(m_pending || m_verifying));
        check("ram_rw",   32'(rw),    32'(m_pending));
        check("verify_err", 32'(verr), 32'(m_err));
        if (m_pending) begin
            check("wr_addr", 32'(address), 32'(m_addr));
            check("wr_data", 32'(dbus),    32'(m_data));
        end
        if (m_verifying) check("rd_addr", 32'(address), 32'(m_base + 16'(m_vidx / 2)));

        // advance the model across the coming rising edge
        if (rst) begin
            if (m_pending) begin
                exp_mem[m_addr] = m_data;
                touched.push_back(m_addr);
                m_writes++;
            end
            m_active = 0; m_release = 0; m_pending = 0; m_verifying = 0; m_err = 0;
            m_left = 0; m_settle_left = 0;
        end else if (m_release) begin
            m_release = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_settle_left = SETTLE; m_left = int'(count); m_count = int'(count);
                m_addr = base; m_base = base; m_err = 0;
            end
        end else if (m_settle_left != 0) begin
            m_settle_left--;
            if (m_settle_left == 0 && m_left == 0) begin
                m_active = 0; m_release = 1;
            end
        end else if (m_pending) begin
            exp_mem[m_addr] = m_data;
            touched.push_back(m_addr);
            m_writes++;
            m_addr = m_addr + 16'd1;
            m_left--;
            m_pending = 0;
            if (m_left == 0) begin
`ifdef LOADER_VERIFY_EN
                m_verifying = 1; m_vidx = 0;
`else
                m_active = 0; m_release = 1;
`endif
            end
        end else if (m_verifying) begin
            m_vidx++;
            if (m_vidx == 2 * m_count) begin
                m_verifying = 0; m_active = 0; m_release = 1;
                m_err = corrupt;
            end
        end else if (valid) begin
            m_pending = 1; m_data = din;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [15:0] words_q[$];

    function automatic logic [15:0] next_word();
        if (words_q.size() > 0) return words_q.pop_front();
        return 16'($urandom);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 valid held, 1 one beat offered every 5 cycles, 2 random 50%
    task automatic run_load(input logic [15:0] b, input logic [15:0] c, input int mode,
                            input bit mid_start, output int halt_cyc, output int en_cyc,
                            output int done_cyc, output int wr_cyc, output int halt_gap,
                            output logic verr_done);
        bit fin;
        bit hs;
        halt_cyc = 0; en_cyc = 0; done_cyc = 0; wr_cyc = 0; halt_gap = 0; verr_done = 1'b0;
        fin = 0;
        base = b; count = c; start = 1'b1; valid = 1'b0; din = next_word();
        step();
        start = 1'b0; base = 16'($urandom); count = 16'($urandom);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (halt) halt_cyc++;
            if (en) en_cyc++;
            if (en && rw) wr_cyc++;
            if (done) begin
                done_cyc++; verr_done = verr; fin = 1;
                valid = 1'b0; start = 1'b0;
                step();
            end else begin
                if (!halt) halt_gap++;
                case (mode)
                    0:       valid = 1'b1;
                    1:       valid = (cyc % 5 == 0);
                    default: valid = ($urandom_range(0, 1) == 1);
                endcase
                start = mid_start && ($urandom_range(0, 3) == 0);
                hs = valid && ready;
                step();
                if (hs) din = next_word();
            end
        end
        valid = 1'b0; start = 1'b0;
        if (!fin) begin
            check("load_timeout", 32'd0, 32'd1);
            rst = 1'b1; step(); rst = 1'b0; step();
        end
    endtask

    initial begin
        int          hc, ec, dc, wc, hg, w0, dn;
        logic        ve;
        logic [15:0] b5, d5;
        bit          hit;

        rst = 1'b1; start = 1'b0; valid = 1'b0; base = '0; count = '0; din = '0;
        repeat (3) step();
        check("reset_halt", 32'(halt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        // 1: three words at 0x0010, valid held
        words_q = '{16'hA001, 16'hA002, 16'hA003};
        run_load(16'h0010, 16'd3, 0, 1'b0, hc, ec, dc, wc, hg, ve);
        check("s1_ram10", 32'(mem[16'h0010]), 32'h0000A001);
        check("s1_ram11", 32'(mem[16'h0011]), 32'h0000A002);
        check("s1_ram12", 32'(mem[16'h0012]), 32'h0000A003);
        check("s1_writes", 32'(wc), 32'd3);
        check("s1_done", 32'(dc), 32'd1);
        check("s1_halt_gap", 32'(hg), 32'd0);
        // SETTLE(2) + 3 x (LOAD + WR)
        check("s1_halt_cycles", 32'(hc), 32'd8);
        check("s1_verify_err", 32'(ve), 32'd0);

        // 2: empty image
        run_load(16'h1234, 16'd0, 0, 1'b0, hc, ec, dc, wc, hg, ve);
        check("s2_halt_cycles", 32'(hc), 32'(SETTLE));
        check("s2_en_cycles", 32'(ec), 32'd0);
        check("s2_done", 32'(dc), 32'd1);

        // 3: address wrap
        words_q = '{16'hBEEF, 16'hCAFE};
        run_load(16'hFFFF, 16'd2, 0, 1'b0, hc, ec, dc, wc, hg, ve);
        check("s3_ramFFFF", 32'(mem[16'hFFFF]), 32'h0000BEEF);
        check("s3_ram0000", 32'(mem[16'h0000]), 32'h0000CAFE);

        // 4: gapped stream plus start requests while busy
        run_load(16'h0200, 16'd4, 1, 1'b1, hc, ec, dc, wc, hg, ve);
        check("s4_writes", 32'(wc), 32'd4);
        check("s4_halt_gap", 32'(hg), 32'd0);
        check("s4_done", 32'(dc), 32'd1);

        // 5: reset during the write of word 2 of 4
        b5 = 16'($urandom); d5 = 16'($urandom);
        w0 = m_writes; hit = 0;
        base = b5; count = 16'd4; start = 1'b1; valid = 1'b1; din = d5;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            if (en && rw && (m_writes - w0) == 1) hit = 1;
            else step();
        end
        check("s5_reached_wr2", 32'(hit), 32'd1);
        rst = 1'b1; valid = 1'b0;
        step();
        rst = 1'b0;
        check("s5_halt", 32'(halt), 32'd0);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_en", 32'(en), 32'd0);
        dn = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (done) dn++;
            step();
        end
        check("s5_no_done", 32'(dn), 32'd0);
        check("s5_word2", 32'(mem[b5 + 16'd1]), 32'(d5));

`ifdef LOADER_VERIFY_EN
        // 6: read-back checksum, clean then with one corrupted word
        run_load(16'h0400, 16'd3, 0, 1'b0, hc, ec, dc, wc, hg, ve);
        check("s6_clean_verr", 32'(ve), 32'd0);
        corrupt_addr = 16'h0401; corrupt = 1'b1;
        run_load(16'h0400, 16'd3, 2, 1'b0, hc, ec, dc, wc, hg, ve);
        check("s6_corrupt_verr", 32'(ve), 32'd1);
        corrupt = 1'b0;
        run_load(16'h0500, 16'd2, 0, 1'b0, hc, ec, dc, wc, hg, ve);
        check("s6_cleared_verr", 32'(ve), 32'd0);
`endif

        // Random loads
        for (int i = 0; i < 12; i++) begin
            run_load(16'($urandom), 16'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
                     ($urandom_range(0, 1) == 1), hc, ec, dc, wc, hg, ve);
            check("rnd_done", 32'(dc), 32'd1);
            step();
        end

        // RAM image against the model
        begin
            int bad;
            bad = 0;
            foreach (touched[k]) if (mem[touched[k]] !== exp_mem[touched[k]]) bad++;
            check("ram_image", 32'(bad), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bat_program_loader
`default_nettype wire
